// File: rtl/load_req_scheduler.sv
// Purpose: round-robin arbiter for DRAM->SRAM load commands; runs one AXI read burst at a time and reports completion.
// Latency: accept -> AR one cycle later; done_vld pulses the cycle after the rlast beat (3 + AR wait + len cycles).
// Backpressure: a command is taken only in IDLE (one-hot req_rdy pulse); AR holds until arrdy; rrdy is high only in DATA.
// Optional feature: define LOAD_SCHED_RETRY_EN to reissue failing bursts up to MAX_RETRY times.
module load_req_scheduler #(
`ifdef LOAD_SCHED_RETRY_EN
    parameter int MAX_RETRY = 3,
`endif
    parameter int NREQ = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_vld,
    output logic [NREQ-1:0]     req_rdy,
    input  logic [NREQ*12-1:0]  req_dram_addr,
    input  logic [NREQ*8-1:0]   req_len,
    input  logic [NREQ*3-1:0]   req_size,
    input  logic [NREQ*2-1:0]   req_sram_type,
    output logic [7:0]          axi_arid,
    output logic [11:0]         axi_araddr,
    output logic [7:0]          axi_arlen,
    output logic [2:0]          axi_arsize,
    output logic [1:0]          axi_arburst,
    output logic                axi_arvld,
    input  logic                axi_arrdy,
    input  logic [7:0]          axi_rid,
    input  logic [1:0]          axi_rresp,
    input  logic                axi_rlast,
    input  logic                axi_rvld,
    output logic                axi_rrdy,
    output logic [1:0]          lb_sram_type,
    output logic                lb_busy,
    output logic                done_vld,
    output logic [NREQ-1:0]     done_req,
    output logic                done_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_AR   = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]       state;
    logic [1:0]       rr_ptr;
    logic [5:0]       txn_tag;
    logic [1:0]       grant_idx;
    logic [NREQ-1:0]  grant_oh;
    logic [7:0]       cur_arid;
    logic [7:0]       beat_cnt;
    logic             err;
`ifdef LOAD_SCHED_RETRY_EN
    logic [1:0]       retry_cnt;
`endif

    // Arbitration results
    logic             gnt_found;
    logic [1:0]       gnt_idx;
    logic [1:0]       rr_nxt;
    logic [NREQ-1:0]  gnt_oh;
    logic [11:0]      sel_addr;
    logic [7:0]       sel_len;
    logic [2:0]       sel_size;
    logic [1:0]       sel_type;

    // Error accumulation for the beat currently on the R channel
    logic             beat_err;
    logic             fin_err;

    // Round-robin pick: first valid requester at or after rr_ptr, plus its payload
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 2'd0;
        gnt_oh    = '0;
        sel_addr  = 12'd0;
        sel_len   = 8'd0;
        sel_size  = 3'd0;
        sel_type  = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!gnt_found && req_vld[j] && (j == (int'(rr_ptr) + i) % NREQ)) begin
                    gnt_found = 1'b1;
                    gnt_idx   = 2'(j);
                end
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            gnt_oh[j] = gnt_found && (int'(gnt_idx) == j);
            if (gnt_oh[j]) begin
                sel_addr = req_dram_addr[12*j +: 12];
                sel_len  = req_len[8*j +: 8];
                sel_size = req_size[3*j +: 3];
                sel_type = req_sram_type[2*j +: 2];
            end
        end
        rr_nxt = 2'((int'(gnt_idx) + 1) % NREQ);
    end

    // Per-beat and end-of-burst error terms; rid is checked against the id actually issued
    always_comb begin
        beat_err = err || (axi_rresp != 2'b00) || (axi_rid != cur_arid);
        fin_err  = beat_err || (beat_cnt != axi_arlen);
    end

    // Main sequencer: grant, AR handshake, beat counting, retry/complete decision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            rr_ptr       <= 2'd0;
            txn_tag      <= 6'd0;
            grant_idx    <= 2'd0;
            grant_oh     <= '0;
            cur_arid     <= 8'd0;
            beat_cnt     <= 8'd0;
            err          <= 1'b0;
            axi_araddr   <= 12'd0;
            axi_arlen    <= 8'd0;
            axi_arsize   <= 3'd0;
            lb_sram_type <= 2'd0;
`ifdef LOAD_SCHED_RETRY_EN
            retry_cnt    <= 2'd0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_found) begin
                        grant_idx    <= gnt_idx;
                        grant_oh     <= gnt_oh;
                        axi_araddr   <= sel_addr;
                        axi_arlen    <= sel_len;
                        axi_arsize   <= sel_size;
                        lb_sram_type <= sel_type;
                        rr_ptr       <= rr_nxt;
                        state        <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (axi_arrdy) begin
                        cur_arid <= axi_arid;
                        txn_tag  <= txn_tag + 6'd1;
                        beat_cnt <= 8'd0;
                        err      <= 1'b0;
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (axi_rvld) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (axi_rlast) begin
                            err <= fin_err;
`ifdef LOAD_SCHED_RETRY_EN
                            if (fin_err && (retry_cnt < 2'(MAX_RETRY))) begin
                                retry_cnt <= retry_cnt + 2'd1;
                                state     <= ST_AR;
                            end else begin
                                state     <= ST_DONE;
                            end
`else
                            state <= ST_DONE;
`endif
                        end else begin
                            err <= beat_err;
                        end
                    end
                end
                default: begin
`ifdef LOAD_SCHED_RETRY_EN
                    retry_cnt <= 2'd0;
`endif
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // State-decoded outputs; req_rdy is forced low while reset is asserted
    always_comb begin
        req_rdy     = (state == ST_IDLE && !rst) ? gnt_oh : '0;
        axi_arid    = {txn_tag, grant_idx};
        axi_arvld   = (state == ST_AR);
        axi_arburst = axi_arvld ? 2'b01 : 2'b00;
        axi_rrdy    = (state == ST_DATA);
        lb_busy     = (state != ST_IDLE);
        done_vld    = (state == ST_DONE);
        done_req    = done_vld ? grant_oh : '0;
        done_err    = done_vld && err;
    end

endmodule

// File: tb/tb_load_req_scheduler.sv
// Directed bench for load_req_scheduler: reset, single burst, round-robin, error/retry, count/id checks, AR stall.
// Completions are predicted into a scoreboard at accept time and compared when done_vld fires.
// Follows the DUT's LOAD_SCHED_RETRY_EN setting for retry-dependent expectations.
module tb_load_req_scheduler;

    localparam int NREQ = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_vld = '0;
    logic [NREQ-1:0]    req_rdy;
    logic [NREQ*12-1:0] req_dram_addr = '0;
    logic [NREQ*8-1:0]  req_len = '0;
    logic [NREQ*3-1:0]  req_size = '0;
    logic [NREQ*2-1:0]  req_sram_type = '0;
    logic [7:0]         axi_arid;
    logic [11:0]        axi_araddr;
    logic [7:0]         axi_arlen;
    logic [2:0]         axi_arsize;
    logic [1:0]         axi_arburst;
    logic               axi_arvld;
    logic               axi_arrdy = 1'b0;
    logic [7:0]         axi_rid = 8'd0;
    logic [1:0]         axi_rresp = 2'd0;
    logic               axi_rlast = 1'b0;
    logic               axi_rvld = 1'b0;
    logic               axi_rrdy;
    logic [1:0]         lb_sram_type;
    logic               lb_busy;
    logic               done_vld;
    logic [NREQ-1:0]    done_req;
    logic               done_err;

    load_req_scheduler #(.NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy),
        .req_dram_addr(req_dram_addr), .req_len(req_len),
        .req_size(req_size), .req_sram_type(req_sram_type),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_arvld(axi_arvld), .axi_arrdy(axi_arrdy),
        .axi_rid(axi_rid), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvld(axi_rvld), .axi_rrdy(axi_rrdy),
        .lb_sram_type(lb_sram_type), .lb_busy(lb_busy),
        .done_vld(done_vld), .done_req(done_req), .done_err(done_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            err;
        logic [NREQ-1:0] req;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    int         tb_rr = 0;
    int         cur_g = 0;
    logic [5:0] tb_tag = 6'd0;
    logic       exp_e;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic set_payload(input int i, input logic [11:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] typ);
        req_dram_addr[i*12 +: 12] = addr;
        req_len[i*8 +: 8]         = len;
        req_size[i*3 +: 3]        = size;
        req_sram_type[i*2 +: 2]   = typ;
    endtask

    task automatic check_zero(input string name);
        check({name, "_ar"}, {req_rdy, axi_arid, axi_araddr, axi_arlen, axi_arsize,
                              axi_arburst, axi_arvld, axi_rrdy}, 64'd0);
        check({name, "_lb"}, {lb_sram_type, lb_busy, done_vld, done_req, done_err}, 64'd0);
    endtask

    // Called at a negedge while the DUT is expected to be in IDLE
    task automatic accept(input logic [NREQ-1:0] vld, input logic hold, input logic exp_err);
        int g;
        logic [NREQ-1:0] oh;
        req_vld = vld;
        #1;
        g  = vld[tb_rr] ? tb_rr : (tb_rr + 1) % NREQ;
        oh = '0;
        oh[g] = 1'b1;
        check("req_rdy_grant", req_rdy, oh);
        sb.push_back({exp_err, oh});
        cur_g = g;
        tb_rr = (g + 1) % NREQ;
        @(negedge clk);
        check("req_rdy_outside_idle", req_rdy, 0);
        check("lb_busy_after_accept", lb_busy, 1);
        if (!hold) req_vld = '0;
    endtask

    // One AR handshake plus nbeats R beats; optional stall, bad response, bad id
    task automatic do_burst(input int stall, input int nbeats, input int bad_beat,
                            input logic [1:0] bad_resp, input logic bad_rid);
        int n;
        logic [7:0] exp_id;
        exp_id = {tb_tag, 2'(cur_g)};
        n = 0;
        while (!axi_arvld && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("arvld", axi_arvld, 1);
        check("araddr", axi_araddr, req_dram_addr[cur_g*12 +: 12]);
        check("arlen", axi_arlen, req_len[cur_g*8 +: 8]);
        check("arsize", axi_arsize, req_size[cur_g*3 +: 3]);
        check("arburst", axi_arburst, 2'b01);
        check("arid", axi_arid, exp_id);
        check("no_done_in_ar", done_vld, 0);
        for (int s = 0; s < stall; s++) begin
            axi_arrdy = 1'b0;
            axi_rvld  = (s == 0);
            axi_rlast = (s == 0);
            #1;
            check("rrdy_low_in_ar", axi_rrdy, 0);
            @(negedge clk);
            axi_rvld  = 1'b0;
            axi_rlast = 1'b0;
            check("stall_arvld", axi_arvld, 1);
            check("stall_payload", {axi_arid, axi_araddr, axi_arlen, axi_arsize},
                  {exp_id, req_dram_addr[cur_g*12 +: 12], req_len[cur_g*8 +: 8], req_size[cur_g*3 +: 3]});
        end
        axi_arrdy = 1'b1;
        @(negedge clk);
        axi_arrdy = 1'b0;
        tb_tag = tb_tag + 6'd1;
        check("rrdy_in_data", axi_rrdy, 1);
        check("lb_sram_type", lb_sram_type, req_sram_type[cur_g*2 +: 2]);
        for (int b = 0; b < nbeats; b++) begin
            axi_rvld  = 1'b1;
            axi_rid   = (bad_rid && b == bad_beat) ? (exp_id ^ 8'h80) : exp_id;
            axi_rresp = (b == bad_beat) ? bad_resp : 2'b00;
            axi_rlast = (b == nbeats - 1);
            @(negedge clk);
        end
        axi_rvld  = 1'b0;
        axi_rlast = 1'b0;
        axi_rresp = 2'b00;
    endtask

    task automatic wait_done();
        int n;
        exp_t e;
        n = 0;
        while (!done_vld && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done_vld", done_vld, 1);
        check("done_after_rlast", n, 0);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            check("done_req", done_req, e.req);
            check("done_err", done_err, e.err);
        end
        @(negedge clk);
        check("done_pulse_1cyc", done_vld, 0);
        check("idle_after_done", lb_busy, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single OKAY burst from requester 0
        set_payload(0, 12'h100, 8'd3, 3'd2, 2'd2);
        set_payload(1, 12'h0AB, 8'd0, 3'd1, 2'd1);
        accept(2'b01, 1'b0, 1'b0);
        do_burst(0, 4, -1, 2'b00, 1'b0);
        wait_done();

        // Both requesters held valid: alternating grants, incrementing tags
        set_payload(0, 12'h200, 8'd1, 3'd3, 2'd1);
        set_payload(1, 12'h300, 8'd0, 3'd2, 2'd3);
        for (int k = 0; k < 4; k++) begin
            accept(2'b11, 1'b1, 1'b0);
            do_burst(0, int'(req_len[cur_g*8 +: 8]) + 1, -1, 2'b00, 1'b0);
            wait_done();
        end
        req_vld = '0;

        // SLVERR on beat 2
        set_payload(0, 12'h100, 8'd3, 3'd2, 2'd2);
`ifdef LOAD_SCHED_RETRY_EN
        exp_e = 1'b0;
`else
        exp_e = 1'b1;
`endif
        accept(2'b01, 1'b0, exp_e);
        do_burst(0, 4, 2, 2'b10, 1'b0);
`ifdef LOAD_SCHED_RETRY_EN
        do_burst(0, 4, -1, 2'b00, 1'b0);
`endif
        wait_done();

        // Persistent failure on single-beat bursts
        set_payload(0, 12'h040, 8'd0, 3'd2, 2'd0);
        accept(2'b01, 1'b0, 1'b1);
`ifdef LOAD_SCHED_RETRY_EN
        repeat (4) do_burst(0, 1, 0, 2'b11, 1'b0);
`else
        do_burst(0, 1, 0, 2'b11, 1'b0);
`endif
        wait_done();

        // Early rlast: 3 beats for len=3
        set_payload(1, 12'h0AB, 8'd3, 3'd1, 2'd1);
        accept(2'b10, 1'b0, exp_e);
        do_burst(0, 3, -1, 2'b00, 1'b0);
`ifdef LOAD_SCHED_RETRY_EN
        do_burst(0, 4, -1, 2'b00, 1'b0);
`endif
        wait_done();

        // rid mismatch on first beat
        set_payload(0, 12'h555, 8'd1, 3'd2, 2'd3);
        accept(2'b01, 1'b0, exp_e);
        do_burst(0, 2, 0, 2'b00, 1'b1);
`ifdef LOAD_SCHED_RETRY_EN
        do_burst(0, 2, -1, 2'b00, 1'b0);
`endif
        wait_done();

        // arrdy held low 5 cycles: payload must stay put, stray R beat ignored
        set_payload(1, 12'hABC, 8'd2, 3'd4, 2'd2);
        accept(2'b10, 1'b0, 1'b0);
        do_burst(5, 3, -1, 2'b00, 1'b0);
        wait_done();

        // Reset in the middle of a DATA phase
        set_payload(0, 12'h123, 8'd3, 3'd2, 2'd1);
        accept(2'b01, 1'b0, 1'b0);
        axi_arrdy = 1'b1;
        @(negedge clk);
        axi_arrdy = 1'b0;
        axi_rvld  = 1'b1;
        axi_rid   = {tb_tag, 2'(cur_g)};
        @(negedge clk);
        axi_rvld  = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check_zero("midburst_reset");
        rst = 1'b0;
        sb.delete();
        tb_rr  = 0;
        tb_tag = 6'd0;
        @(negedge clk);
        check("idle_after_reset", lb_busy, 0);

        // Post-reset transaction starts again from tag 0 and pointer 0
        set_payload(1, 12'h0F0, 8'd0, 3'd2, 2'd2);
        accept(2'b11, 1'b0, 1'b0);
        do_burst(0, int'(req_len[cur_g*8 +: 8]) + 1, -1, 2'b00, 1'b0);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
